fetch_ir_feeder: RTL and testbench

- Instruction-fetch sequencer for the multicycle MIPS datapath.
- Drives the memory read handshake and buffers returned words in a small prefetch FIFO.
- Drives the load strobe and data of the downstream 32-bit Instruction Register (IR).
- Sits between the instruction-memory port and the IR load register. It also supports PC redirect (branch/jump) with flush of stale fetches.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_ir_feeder.sv | 139 +++++++++++++
 tb/tb_fetch_ir_feeder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch feeder
// and its prefetch FIFO.
package fetch_pkg;

    localparam int WORD_W = 32;

    // First fetch address after reset unless the instance overrides it.
    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    // One prefetched instruction together with the address it came from.
    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of {pc, instr} pairs.
// The head entry is read straight from registered storage. A flush empties
// the FIFO and overrides any push or pop in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic           CLK,
    input  logic           RESET_N,
    input  logic           push,
    input  logic           pop,
    input  logic           flush,
    input  fetch_entry_t   wr_entry,
    output fetch_entry_t   head,
    output logic [CW-1:0]  count
);

    fetch_entry_t  slots [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush;
    assign head    = slots[rd_ptr];

    // Storage write and pointer/occupancy update.
    // NOTE: the storage is reset (not just the pointers) because the head
    // drives ir_d/ir_pc directly, and those must read zero out of reset.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= wr_entry;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CW'(do_push) - CW'(do_pop);
            end
        end
    end

endmodule

// File: rtl/fetch_ir_feeder.sv
// fetch_ir_feeder: instruction-fetch sequencer for the multicycle MIPS
// datapath. Issues single-outstanding reads to instruction memory, buffers
// returned words in fetch_fifo and feeds the IR load register. A PC
// redirect (pc_ld) flushes buffered words and discards an in-flight read.
// Optional feature macro: FETCH_BYPASS_EN -- when defined, a word arriving
// while the FIFO is empty and the IR is ready goes straight to ir_d/ir_pc
// in the same cycle instead of being pushed.
module fetch_ir_feeder
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int                PC_INC   = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              pc_ld,
    input  logic [WORD_W-1:0] pc_in,
    output logic              mem_req,
    output logic [WORD_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              ir_ready,
    output logic              ir_ld,
    output logic [WORD_W-1:0] ir_d,
    output logic [WORD_W-1:0] ir_pc,
    output logic              busy
);

    localparam int                CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]     FULL = CW'(DEPTH);
    localparam logic [WORD_W-1:0] INC  = WORD_W'(PC_INC);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [WORD_W-1:0] fetch_pc;
    logic [WORD_W-1:0] fetch_pc_nxt;
    logic [WORD_W-1:0] hold_addr;
    logic [CW-1:0]     count;
    fetch_entry_t      head;
    logic              accept;
    logic              bypass;
    logic              push;
    logic              pop;
    logic              room_now;
    logic              room_after;

    // A useful word arrives: a live request is acked and no redirect kills it.
    assign accept = (state == REQ) && mem_ack && !pc_ld;
    assign pop    = (count != '0) && ir_ready && !pc_ld;
    assign push   = accept && !bypass;

    // Room for a new request once this cycle's pop is counted, and room
    // left after this cycle's push and pop both land.
    assign room_now   = (count - CW'(pop)) < FULL;
    assign room_after = (count + CW'(push) - CW'(pop)) < FULL;

`ifdef FETCH_BYPASS_EN
    // Forward an arriving word straight to the IR when nothing is queued.
    assign bypass = accept && (count == '0) && ir_ready;
    assign ir_ld  = pop || bypass;
    assign ir_d   = bypass ? mem_rdata : head.instr;
    assign ir_pc  = bypass ? fetch_pc : head.pc;
`else
    // Every word goes through the FIFO; ir_ld never depends on mem_ack.
    assign bypass = 1'b0;
    assign ir_ld  = pop;
    assign ir_d   = head.instr;
    assign ir_pc  = head.pc;
`endif

    assign busy = mem_req || (count != '0);

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .push     (push),
        .pop      (pop),
        .flush    (pc_ld),
        .wr_entry ('{pc: fetch_pc, instr: mem_rdata}),
        .head     (head),
        .count    (count)
    );

    // State, fetch address and the address held during a discarded read.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            hold_addr <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            if (state == REQ) begin
                hold_addr <= fetch_pc;
            end
        end
    end

    // Next-state, next fetch address and memory-port outputs.
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        mem_req      = 1'b0;
        mem_addr     = fetch_pc;
        case (state)
            IDLE: begin
                if (pc_ld || room_now) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (pc_ld) begin
                    state_nxt = mem_ack ? REQ : DISCARD;
                end else if (mem_ack) begin
                    fetch_pc_nxt = fetch_pc + INC;
                    state_nxt    = room_after ? REQ : IDLE;
                end
            end
            DISCARD: begin
                mem_req  = 1'b1;
                mem_addr = hold_addr;
                if (mem_ack) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (pc_ld) begin
            fetch_pc_nxt = pc_in;
        end
    end

endmodule

// File: tb/tb_fetch_ir_feeder.sv
// tb_fetch_ir_feeder: self-checking bench for fetch_ir_feeder (DEPTH=2).
// The reference model tracks the program-order instruction stream: words
// accepted from memory queue up in order, a redirect empties the queue and
// restarts the expected address, and an in-flight read at redirect time is
// dropped. Directed scenarios add hand-computed literal checks.
module tb_fetch_ir_feeder;
    import fetch_pkg::*;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] d;
    } ent_t;

    logic        CLK;
    logic        RESET_N;
    logic        pc_ld;
    logic [31:0] pc_in;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        ir_ready;
    logic        ir_ld;
    logic [31:0] ir_d;
    logic [31:0] ir_pc;
    logic        busy;

    int n_total;
    int n_pass;
    int wait_states;
    int wcnt;
    int acks_seen;

    fetch_ir_feeder #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000),
        .PC_INC   (4)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .pc_ld     (pc_ld),
        .pc_in     (pc_in),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ir_ready  (ir_ready),
        .ir_ld     (ir_ld),
        .ir_d      (ir_d),
        .ir_pc     (ir_pc),
        .busy      (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Instruction memory contents as a function of address.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a ^ 32'hDEAD_0000) + 32'h0000_1111;
    endfunction

    // Memory: fixed number of wait states per request, data from memfn.
    assign mem_rdata = memfn(mem_addr);
    assign mem_ack   = mem_req && (wcnt >= wait_states);

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wcnt      <= 0;
            acks_seen <= 0;
        end else if (mem_req && mem_ack) begin
            wcnt      <= 0;
            acks_seen <= acks_seen + 1;
        end else if (mem_req) begin
            wcnt <= wcnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model and per-cycle compare, sampled mid-cycle.
    ent_t        q[$];
    logic [31:0] exp_req;
    logic [31:0] prev_addr;
    bit          discarding;
    bit          prev_wait;
    bit          exp_ld;

    always @(negedge CLK) begin
        if (!RESET_N) begin
            q.delete();
            exp_req    = 32'h0000_0000;
            discarding = 1'b0;
            prev_wait  = 1'b0;
        end else begin
            exp_ld = (q.size() != 0) && ir_ready && !pc_ld;
            check("ir_ld", {31'b0, ir_ld}, {31'b0, exp_ld});
            check("busy", {31'b0, busy}, {31'b0, (mem_req || q.size() != 0)});
            if (prev_wait) begin
                check("req_held", {31'b0, mem_req}, 32'd1);
                check("addr_held", mem_addr, prev_addr);
            end
            if (mem_req) begin
                check("slot_rule", {31'b0, ((q.size() - int'(exp_ld)) < DEPTH)}, 32'd1);
            end
            if (exp_ld) begin
                check("ir_pc", ir_pc, q[0].pc);
                check("ir_d", ir_d, q[0].d);
                void'(q.pop_front());
            end
            if (mem_req && mem_ack) begin
                if (discarding) begin
                    discarding = 1'b0;
                end else begin
                    check("ack_addr", mem_addr, exp_req);
                    if (!pc_ld) begin
                        q.push_back(ent_t'{pc: exp_req, d: memfn(exp_req)});
                    end
                    exp_req = exp_req + 32'd4;
                end
            end
            if (pc_ld) begin
                q.delete();
                exp_req = pc_in;
                if (mem_req && !mem_ack) begin
                    discarding = 1'b1;
                end
            end
            prev_wait = mem_req && !mem_ack;
            prev_addr = mem_addr;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // Hold reset across a falling edge, release it between edges.
    task automatic do_reset(input int ws, input logic rdy);
        RESET_N     = 1'b0;
        pc_ld       = 1'b0;
        pc_in       = 32'h0;
        ir_ready    = rdy;
        wait_states = ws;
        @(negedge CLK);
        #2;
        RESET_N = 1'b1;
    endtask

    initial begin
        n_total     = 0;
        n_pass      = 0;
        RESET_N     = 1'b0;
        pc_ld       = 1'b0;
        pc_in       = 32'h0;
        ir_ready    = 1'b1;
        wait_states = 0;
        #3;
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_ir_ld", {31'b0, ir_ld}, 32'd0);
        check("rst_ir_d", ir_d, 32'h0);
        check("rst_ir_pc", ir_pc, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);

        // 1: zero-wait streaming, IR always ready.
        do_reset(0, 1'b1);
        tick();
        check("t1_c1_req", {31'b0, mem_req}, 32'd1);
        check("t1_c1_addr", mem_addr, 32'h0);
        check("t1_c1_ld", {31'b0, ir_ld}, 32'd0);
        tick();
        check("t1_c2_ld", {31'b0, ir_ld}, 32'd1);
        check("t1_c2_pc", ir_pc, 32'h0);
        check("t1_c2_d", ir_d, 32'hDEAD_1111);
        check("t1_c2_addr", mem_addr, 32'h4);
        tick();
        check("t1_c3_pc", ir_pc, 32'h4);
        check("t1_c3_d", ir_d, 32'hDEAD_1115);
        check("t1_c3_addr", mem_addr, 32'h8);
        repeat (5) tick();

        // 2: IR stalled, FIFO fills after exactly DEPTH acks.
        do_reset(0, 1'b0);
        repeat (10) tick();
        check("t2_acks", acks_seen, 32'd2);
        check("t2_req_off", {31'b0, mem_req}, 32'd0);
        check("t2_busy", {31'b0, busy}, 32'd1);
        ir_ready = 1'b1;
        #1;
        check("t2_pop0_ld", {31'b0, ir_ld}, 32'd1);
        check("t2_pop0_pc", ir_pc, 32'h0);
        tick();
        check("t2_pop1_pc", ir_pc, 32'h4);
        check("t2_resume_req", {31'b0, mem_req}, 32'd1);
        check("t2_resume_addr", mem_addr, 32'h8);
        tick();
        check("t2_pop2_pc", ir_pc, 32'h8);
        repeat (4) tick();

        // 3: three wait states; address stable, single push per ack.
        do_reset(3, 1'b1);
        tick();
        check("t3_c1_addr", mem_addr, 32'h0);
        repeat (3) tick();
        check("t3_c4_addr", mem_addr, 32'h0);
        check("t3_c4_ld", {31'b0, ir_ld}, 32'd0);
        tick();
        check("t3_c5_ld", {31'b0, ir_ld}, 32'd1);
        check("t3_c5_pc", ir_pc, 32'h0);
        check("t3_c5_addr", mem_addr, 32'h4);
        tick();
        check("t3_c6_nodup", {31'b0, ir_ld}, 32'd0);
        repeat (12) tick();

        // 4: redirect during a wait state.
        do_reset(3, 1'b1);
        tick();
        tick();
        pc_ld = 1'b1;
        pc_in = 32'h0000_0100;
        #1;
        check("t4_redir_ld", {31'b0, ir_ld}, 32'd0);
        tick();
        pc_ld = 1'b0;
        check("t4_disc_req", {31'b0, mem_req}, 32'd1);
        check("t4_disc_addr", mem_addr, 32'h0);
        tick();
        check("t4_disc_ack_addr", mem_addr, 32'h0);
        tick();
        check("t4_new_addr", mem_addr, 32'h100);
        tick();
        check("t4_dropped", {31'b0, ir_ld}, 32'd0);
        repeat (3) tick();
        check("t4_first_ld", {31'b0, ir_ld}, 32'd1);
        check("t4_first_pc", ir_pc, 32'h100);
        check("t4_first_d", ir_d, 32'hDEAD_1211);
        repeat (4) tick();

        // 5: redirect coinciding with an ack while the FIFO holds a word.
        do_reset(0, 1'b0);
        tick();
        tick();
        ir_ready = 1'b1;
        pc_ld    = 1'b1;
        pc_in    = 32'h0000_0200;
        #1;
        check("t5_forced_ld0", {31'b0, ir_ld}, 32'd0);
        tick();
        pc_ld = 1'b0;
        check("t5_next_addr", mem_addr, 32'h200);
        check("t5_flushed", {31'b0, ir_ld}, 32'd0);
        tick();
        check("t5_first_pc", ir_pc, 32'h200);
        check("t5_first_d", ir_d, 32'hDEAD_1311);
        repeat (3) tick();

        // 6: address wrap, then asynchronous reset mid-request.
        do_reset(0, 1'b1);
        tick();
        pc_ld = 1'b1;
        pc_in = 32'hFFFF_FFFC;
        tick();
        pc_ld = 1'b0;
        check("t6_top_addr", mem_addr, 32'hFFFF_FFFC);
        tick();
        check("t6_wrap_addr", mem_addr, 32'h0);
        check("t6_top_pc", ir_pc, 32'hFFFF_FFFC);
        check("t6_top_d", ir_d, 32'h2153_110D);
        #1;
        RESET_N = 1'b0;
        #1;
        check("t6_arst_req", {31'b0, mem_req}, 32'd0);
        check("t6_arst_addr", mem_addr, 32'h0);
        check("t6_arst_ld", {31'b0, ir_ld}, 32'd0);
        check("t6_arst_d", ir_d, 32'h0);
        check("t6_arst_pc", ir_pc, 32'h0);
        check("t6_arst_busy", {31'b0, busy}, 32'd0);
        @(negedge CLK);
        #2;
        RESET_N = 1'b1;
        tick();
        check("t6_restart_addr", mem_addr, 32'h0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
